// File: rtl/instr_encode_loader.sv
// Instruction encode loader: packs decoded RV32I field bundles into 32-bit instruction words
// and streams them into IMEM at consecutive word addresses. The first illegal bundle aborts
// the session.
module instr_encode_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_kind_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [2:0]        in_funct3_i,
  input  logic              in_alt_i,
  input  logic [31:0]       in_imm_i,
  input  logic              in_last_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        err_code_o,
  output logic [ADDR_W:0]   count_o
);

  // Address is kept one bit wider than IMEM so a target past the top is detectable.
  localparam logic [ADDR_W:0] BaseAddr = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] AddrOne  = (ADDR_W + 1)'(1);

  localparam logic [3:0] KindLui    = 4'd0;
  localparam logic [3:0] KindAuipc  = 4'd1;
  localparam logic [3:0] KindJal    = 4'd2;
  localparam logic [3:0] KindJalr   = 4'd3;
  localparam logic [3:0] KindBranch = 4'd4;
  localparam logic [3:0] KindLoad   = 4'd5;
  localparam logic [3:0] KindStore  = 4'd6;
  localparam logic [3:0] KindOpImm  = 4'd7;
  localparam logic [3:0] KindOp     = 4'd8;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam logic [6:0] F7Alt = 7'b0100000;

  localparam logic [2:0] ErrNone  = 3'd0;
  localparam logic [2:0] ErrKind  = 3'd1;
  localparam logic [2:0] ErrImm   = 3'd2;
  localparam logic [2:0] ErrFunct = 3'd3;
  localparam logic [2:0] ErrOvf   = 3'd4;

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [2:0]        err_code_q, err_code_d;

  logic [31:0]       enc_word;
  logic              kind_bad, f3_bad, imm_bad;
  logic              imm_s12, imm_s13, imm_s21;
  logic              is_shift;
  logic [ADDR_W:0]   tgt_addr;
  logic              ovf;
  logic [2:0]        chk_code;
  logic              accept, complete;

  // "Signed N-bit": every bit above N-1 equals bit N-1.
  assign imm_s12  = (in_imm_i[31:11] == {21{in_imm_i[11]}});
  assign imm_s13  = (in_imm_i[31:12] == {20{in_imm_i[12]}});
  assign imm_s21  = (in_imm_i[31:20] == {12{in_imm_i[20]}});
  assign is_shift = (in_funct3_i == 3'b001) || (in_funct3_i == 3'b101);

  // Encode the bundle and classify legality for its format.
  always_comb begin
    enc_word = '0;
    kind_bad = 1'b0;
    f3_bad   = 1'b0;
    imm_bad  = 1'b0;
    case (in_kind_i)
      KindLui: begin
        enc_word = {in_imm_i[31:12], in_rd_i, OpLui};
        imm_bad  = |in_imm_i[11:0];
      end
      KindAuipc: begin
        enc_word = {in_imm_i[31:12], in_rd_i, OpAuipc};
        imm_bad  = |in_imm_i[11:0];
      end
      KindJal: begin
        enc_word = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12], in_rd_i, OpJal};
        imm_bad  = !imm_s21 || in_imm_i[0];
      end
      KindJalr: begin
        enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, OpJalr};
        f3_bad   = (in_funct3_i != 3'b000);
        imm_bad  = !imm_s12;
      end
      KindBranch: begin
        enc_word = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                    in_imm_i[4:1], in_imm_i[11], OpBranch};
        f3_bad   = (in_funct3_i == 3'b010) || (in_funct3_i == 3'b011);
        imm_bad  = !imm_s13 || in_imm_i[0];
      end
      KindLoad: begin
        enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, OpLoad};
        // Legal widths: 000,001,010,100,101.
        f3_bad   = (in_funct3_i == 3'b011) || (in_funct3_i[2:1] == 2'b11);
        imm_bad  = !imm_s12;
      end
      KindStore: begin
        enc_word = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], OpStore};
        f3_bad   = (in_funct3_i > 3'b010);
        imm_bad  = !imm_s12;
      end
      KindOpImm: begin
        if (is_shift) begin
          enc_word = {(in_alt_i ? F7Alt : 7'b0), in_imm_i[4:0], in_rs1_i, in_funct3_i, in_rd_i,
                      OpOpImm};
          f3_bad   = in_alt_i && (in_funct3_i == 3'b001);
          imm_bad  = |in_imm_i[31:5];
        end else begin
          enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, OpOpImm};
          imm_bad  = !imm_s12;
        end
      end
      KindOp: begin
        enc_word = {(in_alt_i ? F7Alt : 7'b0), in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, OpOp};
        f3_bad   = in_alt_i && !((in_funct3_i == 3'b000) || (in_funct3_i == 3'b101));
      end
      default: kind_bad = 1'b1;
    endcase
  end

  // Target of a new bundle: current address, or the next one if the pending word retires now.
  assign tgt_addr = addr_q + {{ADDR_W{1'b0}}, we_q};
  assign ovf      = tgt_addr[ADDR_W];

  // Error code with priority kind > funct3/alt > imm > overflow.
  always_comb begin
    chk_code = ErrNone;
    if (kind_bad)     chk_code = ErrKind;
    else if (f3_bad)  chk_code = ErrFunct;
    else if (imm_bad) chk_code = ErrImm;
    else if (ovf)     chk_code = ErrOvf;
  end

  // Once the last bundle is held, nothing more is taken.
  assign in_ready_o = (state_q == StLoad) && (!we_q || imem_ready_i) && !last_q;
  assign accept     = in_valid_i && in_ready_o;
  assign complete   = we_q && imem_ready_i;

  // Next-state: write retirement, bundle acceptance, then start overriding both.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (complete) begin
      we_d    = 1'b0;
      last_d  = 1'b0;
      addr_d  = addr_q + AddrOne;
      count_d = count_q + AddrOne;
      if (last_q) begin
        state_d = StDone;
        done_d  = 1'b1;
      end
    end

    if (accept) begin
      if (chk_code != ErrNone) begin
        state_d    = StErr;
        err_d      = 1'b1;
        err_code_d = chk_code;
      end else begin
        we_d    = 1'b1;
        wdata_d = enc_word;
        last_d  = in_last_i;
      end
    end

    // A new session discards any pending write.
    if (start_i) begin
      state_d    = StLoad;
      addr_d     = BaseAddr;
      count_d    = '0;
      we_d       = 1'b0;
      last_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = ErrNone;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= BaseAddr;
      count_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q[ADDR_W-1:0];
  assign imem_wdata_o = wdata_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: default instance plus a 2-bit-address instance.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, imem_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_alt, in_last;
  logic [31:0] in_imm;

  logic        in_ready, imem_we, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  err_code;
  logic [10:0] count;

  logic        start2, in_valid2;
  logic        in_ready2, imem_we2, done2, err2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  err_code2;
  logic [2:0]  count2;

  instr_encode_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_kind_i(in_kind), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_funct3_i(in_funct3), .in_alt_i(in_alt), .in_imm_i(in_imm), .in_last_i(in_last),
    .imem_we_o(imem_we), .imem_ready_i(imem_ready), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .done_o(done), .err_o(err), .err_code_o(err_code),
    .count_o(count)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in_kind_i(in_kind), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_funct3_i(in_funct3), .in_alt_i(in_alt), .in_imm_i(in_imm), .in_last_i(in_last),
    .imem_we_o(imem_we2), .imem_ready_i(imem_ready), .imem_addr_o(imem_addr2),
    .imem_wdata_o(imem_wdata2), .done_o(done2), .err_o(err2), .err_code_o(err_code2),
    .count_o(count2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fields(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [31:0] imm, input logic last);
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_alt = alt; in_imm = imm; in_last = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  logic [31:0] stream_exp [5];

  initial begin
    stream_exp[0] = 32'h402081B3;
    stream_exp[1] = 32'hFE208CE3;
    stream_exp[2] = 32'h001000EF;
    stream_exp[3] = 32'h123452B7;
    stream_exp[4] = 32'h0020A423;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
    start2 = 1'b0; in_valid2 = 1'b0;
    fields(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0);
    tick(); tick();

    // Reset state
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_count", count, 0);

    rst = 1'b0;
    do_start();
    chk("start_ready", in_ready, 1);

    // ADDI x1,x0,5 then ADDI x2,x0,7 with IMEM stalled
    imem_ready = 1'b0;
    fields(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    in_valid = 1'b1;
    #1 chk("addi_ready", in_ready, 1);
    tick();
    fields(4'd7, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, 1'b0);
    #1;
    chk("addi_we", imem_we, 1);
    chk("addi_addr", imem_addr, 0);
    chk("addi_wdata", imem_wdata, 32'h00500093);
    chk("stall_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_we", imem_we, 1);
      chk("stall_addr", imem_addr, 0);
      chk("stall_wdata", imem_wdata, 32'h00500093);
      chk("stall_ready", in_ready, 0);
      chk("stall_count", count, 0);
    end
    imem_ready = 1'b1;
    #1 chk("release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("second_we", imem_we, 1);
    chk("second_addr", imem_addr, 1);
    chk("second_wdata", imem_wdata, 32'h00700113);
    chk("second_count", count, 1);
    tick();
    chk("drain_we", imem_we, 0);
    chk("drain_count", count, 2);
    chk("drain_addr", imem_addr, 2);

    // ADDI imm 0x800 is out of range
    fields(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("imm_err", err, 1);
    chk("imm_code", err_code, 2);
    chk("imm_we", imem_we, 0);
    chk("imm_ready", in_ready, 0);
    chk("imm_done", done, 0);
    chk("imm_count", count, 2);
    tick();
    chk("imm_err_held", err, 1);

    do_start();
    chk("restart_err", err, 0);
    chk("restart_code", err_code, 0);
    chk("restart_count", count, 0);
    chk("restart_addr", imem_addr, 0);
    chk("restart_ready", in_ready, 1);

    // Back-to-back stream ending with in_last
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: fields(4'd8, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0);
        1: fields(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFF8, 1'b0);
        2: fields(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800, 1'b0);
        3: fields(4'd0, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b0);
        default: fields(4'd6, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b1);
      endcase
      in_valid = 1'b1;
      tick();
      chk("stream_we", imem_we, 1);
      chk("stream_addr", imem_addr, i);
      chk("stream_wdata", imem_wdata, stream_exp[i]);
      chk("stream_count", count, i);
    end
    in_valid = 1'b0;
    #1;
    chk("last_ready", in_ready, 0);
    chk("last_done_early", done, 0);
    tick();
    chk("done", done, 1);
    chk("done_count", count, 5);
    chk("done_we", imem_we, 0);
    chk("done_err", err, 0);
    chk("done_ready", in_ready, 0);
    fields(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("done_noaccept_we", imem_we, 0);
    chk("done_noaccept_count", count, 5);
    chk("done_held", done, 1);

    // Priority: funct3 beats imm
    do_start();
    chk("start_clears_done", done, 0);
    fields(4'd3, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 32'h00000800, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("jalr_f3_code", err_code, 3);

    // Priority: kind beats everything
    do_start();
    fields(4'd9, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 32'h00000800, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("kind_code", err_code, 1);

    // SLLI with alt is illegal
    do_start();
    fields(4'd7, 5'd1, 5'd2, 5'd0, 3'd1, 1'b1, 32'd3, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("slli_alt_code", err_code, 3);

    // SRAI x4,x5,2
    do_start();
    fields(4'd7, 5'd4, 5'd5, 5'd0, 3'd5, 1'b1, 32'd2, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("srai_wdata", imem_wdata, 32'h4022D213);
    chk("srai_err", err, 0);

    // LOAD funct3 011 is illegal
    do_start();
    fields(4'd5, 5'd1, 5'd2, 5'd0, 3'd3, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("load_f3_code", err_code, 3);

    // Branch immediate at the top of range, then one past it
    do_start();
    fields(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4094, 1'b0);
    in_valid = 1'b1;
    tick();
    #1 chk("beq_max_wdata", imem_wdata, 32'h7E000FE3);
    fields(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("beq_ovr_code", err_code, 2);
    chk("beq_ovr_count", count, 1);
    chk("beq_ovr_we", imem_we, 0);

    // start drops a pending write
    do_start();
    imem_ready = 1'b0;
    fields(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("pend_we", imem_we, 1);
    do_start();
    chk("startdrop_we", imem_we, 0);
    chk("startdrop_addr", imem_addr, 0);
    chk("startdrop_count", count, 0);
    chk("startdrop_ready", in_ready, 1);

    // rst drops a pending write
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("pend2_we", imem_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstdrop_we", imem_we, 0);
    chk("rstdrop_ready", in_ready, 0);
    chk("rstdrop_addr", imem_addr, 0);
    chk("rstdrop_count", count, 0);
    chk("rstdrop_wdata", imem_wdata, 0);
    imem_ready = 1'b1;

    // ADDR_W=2: four words fit, the fifth overflows
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    fields(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      tick();
      chk("small_we", imem_we2, 1);
      chk("small_addr", imem_addr2, i);
      chk("small_count", count2, i);
    end
    tick();
    in_valid2 = 1'b0;
    #1;
    chk("ovf_err", err2, 1);
    chk("ovf_code", err_code2, 4);
    chk("ovf_count", count2, 4);
    chk("ovf_we", imem_we2, 0);
    chk("ovf_ready", in_ready2, 0);
    chk("ovf_done", done2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the ID-stage instruction decoder: accepts decoded RV32I fields (class, rd, rs1, rs2, funct3, alt bit, 32-bit immediate) and packs them into 32-bit instruction words.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used by the boot/test loader path to build program images in IMEM.
- Validates that each immediate is representable and each funct3 is legal; aborts the load on the first bad entry.

Parameters:
- ADDR_W, 10, IMEM word-address width.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin new load session
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_kind  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_alt  in  1  SUB/SRA/SRAI select (funct7=0100000)
- in_imm  in  32  byte-offset/value immediate, unencoded
- in_last  in  1  final bundle of the session
- imem_we  out  1  write strobe (valid)
- imem_ready  in  1  IMEM accepts the write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- done  out  1  session completed cleanly
- err  out  1  session aborted
- err_code  out  3  0 none, 1 bad kind, 2 imm range, 3 bad funct3/alt, 4 address overflow
- count  out  ADDR_W+1  words written this session

Behaviour:
- States: IDLE, LOAD, DONE, ERR.
- Reset → IDLE; all outputs 0; address = BASE_ADDR.
- start (in any state) → LOAD; clears count, done, err and err_code; address = BASE_ADDR. start takes priority over a handshake in the same cycle; any pending write is dropped.
- Reset mid-session: the pending write is dropped and imem_we falls on the next edge.
- Handshakes:
  - in_ready = (state==LOAD) && (!imem_we || imem_ready).
  - A bundle is accepted when in_valid && in_ready.
  - The encoded word is registered, so imem_we/imem_wdata/imem_addr appear the cycle after acceptance (1-cycle latency).
  - imem_we, addr and wdata hold stable until imem_ready. A write completes on imem_we && imem_ready; then count++ and address++.
  - Back-to-back accept and complete is allowed, giving 1 word per cycle sustained.
- Encoding (rd field is ignored for BRANCH/STORE; rs1/rs2 fields are ignored where the format has none):
  - U: imm[31:12]. imm[11:0] must be 0.
  - J: imm[20|10:1|11|19:12]. imm must be a signed 21-bit value with bit0 = 0.
  - B: imm[12|10:5] at [31:25], imm[4:1|11] at [11:7]. imm must be signed 13-bit with bit0 = 0. funct3 010/011 is illegal.
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7]. imm must be signed 12-bit. funct3 must be ≤ 010.
  - I (LOAD/JALR/OPIMM): imm[11:0] at [31:20], signed 12-bit.
    - LOAD funct3 must be in {000,001,010,100,101}.
    - JALR funct3 must be 000.
    - OPIMM shifts (001/101): imm[31:5] must be 0; funct7 = in_alt ? 0100000 : 0. in_alt is illegal with 001.
  - R (OP): funct7 = 0100000 if in_alt, allowed only with funct3 000/101; otherwise 0.
  - Opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
  - "Signed N-bit" means in_imm equals the sign-extension of its low N bits.
- Errors:
  - Checked at acceptance. A failing bundle produces no write.
  - The already-registered prior word still completes.
  - State → ERR; err=1 and err_code latched; in_ready=0 until start.
  - Priority: kind > funct3/alt > imm.
  - Overflow: a bundle accepted when its target address would exceed 2^ADDR_W-1 gives err_code 4.
- in_last: after that word's write completes → DONE with done=1 (held until start/rst). No further acceptance.
- err and done are never both 1.

Test Plan:
- ADDI x1,x0,5 (kind 7, f3 000, imm 5) after start → next cycle imem_we=1, addr 0, wdata 0x00500093.
- Stream SUB x3,x1,x2; BEQ x1,x2,-8; JAL x1,2048; LUI x5,0x12345000; SW x2,8(x1) (last), imem_ready=1 → wdata 0x402081B3, 0xFE208CE3, 0x001000EF, 0x123452B7, 0x0020A423 at addr 0–4 on consecutive cycles; done=1, count=5.
- ADDI imm 0x800 → no write, err=1, err_code=2, in_ready=0. Then start → err cleared, in_ready=1.
- imem_ready held low 3 cycles with the next bundle valid → imem_we/addr/wdata stable, in_ready=0, no second accept. Release → both words written in order, none lost.
- ADDR_W=2: 5 bundles → 4 writes to addr 0–3, fifth gives err_code 4, count=4.
- start asserted while imem_we pending, plus rst mid-session → pending write dropped, address back to BASE_ADDR, outputs 0 after rst.
